// File: rtl/vga_console_writer.sv
// Write side of the VGA text buffer: turns a byte stream into cell writes,
// tracking cursor, attribute nibble and a circular top-row pointer for scrolling.
module vga_console_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 15,
  parameter int AW   = $clog2(COLS*ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [11:0]             wr_data,
  output logic [$clog2(ROWS)-1:0] top_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, ESC, CLEAR_ROW} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   r_top;
  logic [3:0]      r_attr;
  logic [AW-1:0]   r_clrAddr;
  logic [CW-1:0]   r_clrCnt;
  logic            r_wrEn;
  logic [AW-1:0]   r_wrAddr;
  logic [11:0]     r_wrData;

  logic [RW:0]     w_sum;
  logic [RW-1:0]   w_physRow;
  logic [AW-1:0]   w_cellAddr;
  logic [AW-1:0]   w_topBase;
  logic [RW-1:0]   w_nextTop;
  logic            w_accept;
  logic            w_printable;
  logic            w_lastCol;
  logic            w_advRow;

  // Logical-to-physical row mapping wraps with a single compare-subtract.
  assign w_sum       = {1'b0, r_top} + {1'b0, r_row};
  assign w_physRow   = (w_sum >= (RW+1)'(ROWS)) ? RW'(w_sum - (RW+1)'(ROWS)) : RW'(w_sum);
  assign w_cellAddr  = AW'(w_physRow) * AW'(COLS) + AW'(r_col);
  assign w_topBase   = AW'(r_top) * AW'(COLS);
  assign w_nextTop   = (r_top == RW'(ROWS-1)) ? '0 : r_top + RW'(1);

  assign in_ready    = (r_state == IDLE) || (r_state == ESC);
  assign w_accept    = in_valid && in_ready;
  assign w_printable = (in_data >= 8'h20) && (in_data != 8'h7F);
  assign w_lastCol   = (r_col == CW'(COLS-1));
  assign w_advRow    = w_accept && (r_state == IDLE) &&
                       ((in_data == 8'h0A) || (w_printable && w_lastCol));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR_ALL;
      r_col     <= '0;
      r_row     <= '0;
      r_top     <= '0;
      r_attr    <= '0;
      r_clrAddr <= '0;
      r_clrCnt  <= '0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
    end else begin
      r_wrEn <= 1'b0;
      case (r_state)
        CLEAR_ALL: begin
          r_wrEn    <= 1'b1;
          r_wrAddr  <= r_clrAddr;
          r_wrData  <= 12'h020;
          r_clrAddr <= r_clrAddr + AW'(1);
          if (r_clrAddr == AW'(CELLS-1)) r_state <= IDLE;
        end
        CLEAR_ROW: begin
          r_wrEn    <= 1'b1;
          r_wrAddr  <= r_clrAddr;
          r_wrData  <= 12'h020;
          r_clrAddr <= r_clrAddr + AW'(1);
          r_clrCnt  <= r_clrCnt + CW'(1);
          if (r_clrCnt == CW'(COLS-1)) r_state <= IDLE;
        end
        ESC: begin
          if (w_accept) begin
            r_attr  <= in_data[3:0];
            r_state <= IDLE;
          end
        end
        default: begin
          if (w_accept) begin
            case (in_data)
              8'h0D, 8'h0A: r_col <= '0;
              8'h08: if (r_col != '0) r_col <= r_col - CW'(1);
              8'h0C: begin
                r_col     <= '0;
                r_row     <= '0;
                r_top     <= '0;
                r_clrAddr <= '0;
                r_state   <= CLEAR_ALL;
              end
              8'h1B: r_state <= ESC;
              default: begin
                if (w_printable) begin
                  r_wrEn   <= 1'b1;
                  r_wrAddr <= w_cellAddr;
                  r_wrData <= {r_attr, in_data};
                  r_col    <= w_lastCol ? '0 : r_col + CW'(1);
                end
              end
            endcase
          end
        end
      endcase
      // Scrolling recycles the old top row as the new bottom row and blanks it.
      if (w_advRow) begin
        if (r_row != RW'(ROWS-1)) begin
          r_row <= r_row + RW'(1);
        end else begin
          r_top     <= w_nextTop;
          r_clrAddr <= w_topBase;
          r_clrCnt  <= '0;
          r_state   <= CLEAR_ROW;
        end
      end
    end
  end

  assign wr_en      = r_wrEn;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign top_row    = r_top;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer: a table of single-byte vectors plus
// hand-written sequences for reset clear, scrolling with held valid, and FF/reset.
module tb_vga_console_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  top_row;
  logic [5:0]  cursor_col;
  logic [3:0]  cursor_row;

  int checks = 0;
  int errors = 0;

  vga_console_writer #(.COLS(40), .ROWS(15)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .top_row(top_row), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        expWr;
    logic [9:0]  expAddr;
    logic [11:0] expData;
    logic [5:0]  expCol;
    logic [3:0]  expRow;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called away from the rising edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCyc = 0;
    while (!in_ready && waitCyc < 1000) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("ready_before_byte", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_wr_en"},    32'(wr_en),      32'd0);
    checkOutput({name, "_wr_addr"},  32'(wr_addr),    32'd0);
    checkOutput({name, "_wr_data"},  32'(wr_data),    32'd0);
    checkOutput({name, "_in_ready"}, 32'(in_ready),   32'd0);
    checkOutput({name, "_top_row"},  32'(top_row),    32'd0);
    checkOutput({name, "_col"},      32'(cursor_col), 32'd0);
    checkOutput({name, "_row"},      32'(cursor_row), 32'd0);
  endtask

  // Collects n blank-fill writes starting at base; in_ready must rise only on the last one.
  task automatic checkClear(input int n, input int base, input string name);
    int cnt = 0, bad = 0, rdyBad = 0, cyc = 0;
    while (cnt < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (wr_en) begin
        if (int'(wr_addr) != base + cnt || wr_data != 12'h020) bad++;
        if (in_ready != (cnt == n - 1)) rdyBad++;
        cnt++;
      end
    end
    checkOutput({name, "_count"}, 32'(cnt),    32'(n));
    checkOutput({name, "_order"}, 32'(bad),    32'd0);
    checkOutput({name, "_ready"}, 32'(rdyBad), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 10'd0, 12'h041, 6'd1, 4'd0};
    vecs[1]  = '{8'h42, 1'b1, 10'd1, 12'h042, 6'd2, 4'd0};
    vecs[2]  = '{8'h1B, 1'b0, 10'd0, 12'h000, 6'd2, 4'd0};
    vecs[3]  = '{8'h05, 1'b0, 10'd0, 12'h000, 6'd2, 4'd0};
    vecs[4]  = '{8'h58, 1'b1, 10'd2, 12'h558, 6'd3, 4'd0};
    vecs[5]  = '{8'h08, 1'b0, 10'd0, 12'h000, 6'd2, 4'd0};
    vecs[6]  = '{8'h08, 1'b0, 10'd0, 12'h000, 6'd1, 4'd0};
    vecs[7]  = '{8'h08, 1'b0, 10'd0, 12'h000, 6'd0, 4'd0};
    vecs[8]  = '{8'h08, 1'b0, 10'd0, 12'h000, 6'd0, 4'd0};
    vecs[9]  = '{8'h01, 1'b0, 10'd0, 12'h000, 6'd0, 4'd0};
    vecs[10] = '{8'h7F, 1'b0, 10'd0, 12'h000, 6'd0, 4'd0};
    vecs[11] = '{8'h80, 1'b1, 10'd0, 12'h580, 6'd1, 4'd0};
    vecs[12] = '{8'h0D, 1'b0, 10'd0, 12'h000, 6'd0, 4'd0};
    vecs[13] = '{8'h1B, 1'b0, 10'd0, 12'h000, 6'd0, 4'd0};
    vecs[14] = '{8'h00, 1'b0, 10'd0, 12'h000, 6'd0, 4'd0};

    repeat (3) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    checkClear(600, 0, "initClear");

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].data);
      checkOutput($sformatf("vec%0d_col", i), 32'(cursor_col), 32'(vecs[i].expCol));
      checkOutput($sformatf("vec%0d_row", i), 32'(cursor_row), 32'(vecs[i].expRow));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].expWr));
      if (vecs[i].expWr) begin
        checkOutput($sformatf("vec%0d_addr", i), 32'(wr_addr), 32'(vecs[i].expAddr));
        checkOutput($sformatf("vec%0d_data", i), 32'(wr_data), 32'(vecs[i].expData));
      end
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'h61);
      @(negedge clk);
      checkOutput($sformatf("fill%0d_wr_en", i), 32'(wr_en), 32'd1);
      checkOutput($sformatf("fill%0d_addr", i), 32'(wr_addr), 32'(i));
      checkOutput($sformatf("fill%0d_data", i), 32'(wr_data), 32'h061);
    end
    checkOutput("wrap_col", 32'(cursor_col), 32'd0);
    checkOutput("wrap_row", 32'(cursor_row), 32'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(8'h0A);
      @(negedge clk);
    end
    checkOutput("lf_row", 32'(cursor_row), 32'd14);
    checkOutput("lf_top", 32'(top_row), 32'd0);

    applyStimulus(8'h0A);
    checkOutput("scroll_top", 32'(top_row), 32'd1);
    checkOutput("scroll_row", 32'(cursor_row), 32'd14);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    checkClear(40, 0, "rowClear");
    checkOutput("held_col_unchanged", 32'(cursor_col), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("held_col", 32'(cursor_col), 32'd1);
    @(negedge clk);
    checkOutput("held_wr_en", 32'(wr_en), 32'd1);
    checkOutput("held_addr", 32'(wr_addr), 32'd0);
    checkOutput("held_data", 32'(wr_data), 32'h05A);

    applyStimulus(8'h1B);
    @(negedge clk);
    applyStimulus(8'h07);
    @(negedge clk);
    applyStimulus(8'h0C);
    checkOutput("ff_top", 32'(top_row), 32'd0);
    checkOutput("ff_col", 32'(cursor_col), 32'd0);
    checkOutput("ff_row", 32'(cursor_row), 32'd0);
    begin
      int cnt = 0, cyc = 0, firstAddr = -1;
      while (cnt < 300 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
        if (wr_en) begin
          if (cnt == 0) firstAddr = int'(wr_addr);
          cnt++;
        end
      end
      checkOutput("ff_clear_first", 32'(firstAddr), 32'd0);
      checkOutput("ff_clear_partial", 32'(cnt), 32'd300);
    end
    rst = 1'b1;
    #1;
    checkReset("midReset");
    @(negedge clk);
    rst = 1'b0;
    checkClear(600, 0, "restartClear");
    checkOutput("final_top", 32'(top_row), 32'd0);
    checkOutput("final_col", 32'(cursor_col), 32'd0);
    checkOutput("final_row", 32'(cursor_row), 32'd0);
    applyStimulus(8'h51);
    @(negedge clk);
    checkOutput("attr_reset_addr", 32'(wr_addr), 32'd0);
    checkOutput("attr_reset_data", 32'(wr_data), 32'h051);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
